// File: rtl/obi_ram_arb_pkg.sv
// Shared definitions for the OBI-to-dual-port-RAM arbiter.
//   port_e : identifies the requesting port (instruction or data)
//   resp_e : what kind of response the data port owes next cycle
//   DEFAULT_* : default RAM geometry
package obi_ram_arb_pkg;

  localparam int unsigned DEFAULT_ADDR_WIDTH = 17;
  localparam int unsigned DEFAULT_DATA_WIDTH = 32;

  typedef enum logic {
    PORT_INSTR = 1'b0,
    PORT_DATA  = 1'b1
  } port_e;

  typedef enum logic [1:0] {
    RESP_NONE  = 2'd0,
    RESP_READ  = 2'd1,
    RESP_WRITE = 2'd2
  } resp_e;

endpackage

// File: rtl/ram_rr_arb2.sv
// Two-way round-robin arbiter for the shared RAM read port.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   req_i[1:0]    : read requests, indexed by port_e
//   gnt_o[1:0]    : one-hot (or zero) grant, indexed by port_e
// The last-winner flop only moves when both requests collide, so an
// uncontested grant never costs a port its turn. After reset the
// instruction port counts as the last winner, so data wins first.
module ram_rr_arb2
  import obi_ram_arb_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  port_e last_q, last_d;

  always_comb begin
    gnt_o  = req_i;
    last_d = last_q;
    if (req_i[PORT_INSTR] && req_i[PORT_DATA]) begin
      gnt_o = 2'b00;
      if (last_q == PORT_INSTR) begin
        gnt_o[PORT_DATA] = 1'b1;
        last_d           = PORT_DATA;
      end else begin
        gnt_o[PORT_INSTR] = 1'b1;
        last_d            = PORT_INSTR;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= PORT_INSTR;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/obi_ram_arbiter.sv
// Connects an OBI instruction port (read-only) and an OBI data port to a
// simple dual-port RAM (port A write-only, port B read-only, 1-cycle read
// latency). Grants are combinational; responses arrive one cycle later.
//   clk_i, rst_ni           : clock, asynchronous active-low reset
//   instr_*                 : OBI instruction port (req/addr -> gnt/rvalid/rdata)
//   data_*                  : OBI data port (req/we/be/addr/wdata -> gnt/rvalid/rdata)
//   ram_addra/wea/dina_o    : RAM write port
//   ram_addrb/enb_o         : RAM read port request
//   ram_doutb_i             : RAM read data, valid the cycle after ram_enb_o
// Handshake: a transaction is accepted in any cycle where req && gnt; the
// matching rvalid is high for exactly the following cycle, and rdata is 0
// whenever rvalid is low. There is no request buffering: an ungranted
// requester simply holds req until it sees gnt.
module obi_ram_arbiter
  import obi_ram_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    instr_req_i,
  input  logic [31:0]             instr_addr_i,
  output logic                    instr_gnt_o,
  output logic                    instr_rvalid_o,
  output logic [DATA_WIDTH-1:0]   instr_rdata_o,
  input  logic                    data_req_i,
  input  logic                    data_we_i,
  input  logic [DATA_WIDTH/8-1:0] data_be_i,
  input  logic [31:0]             data_addr_i,
  input  logic [DATA_WIDTH-1:0]   data_wdata_i,
  output logic                    data_gnt_o,
  output logic                    data_rvalid_o,
  output logic [DATA_WIDTH-1:0]   data_rdata_o,
  output logic [ADDR_WIDTH-1:0]   ram_addra_o,
  output logic [DATA_WIDTH/8-1:0] ram_wea_o,
  output logic [DATA_WIDTH-1:0]   ram_dina_o,
  output logic [ADDR_WIDTH-1:0]   ram_addrb_o,
  output logic                    ram_enb_o,
  input  logic [DATA_WIDTH-1:0]   ram_doutb_i
);

  logic [ADDR_WIDTH-1:0] instr_word, data_word;
  logic                  data_wr, data_rd, instr_rd;
  logic [1:0]            rd_req, rd_gnt;
  logic                  instr_pend_q;
  resp_e                 data_resp_q, data_resp_d;
  logic                  unused_addr_bits;

  assign instr_word = instr_addr_i[ADDR_WIDTH+1:2];
  assign data_word  = data_addr_i[ADDR_WIDTH+1:2];

  // Byte offset and bits above the RAM range carry no meaning here.
  assign unused_addr_bits = ^{instr_addr_i[31:ADDR_WIDTH+2], instr_addr_i[1:0],
                              data_addr_i[31:ADDR_WIDTH+2], data_addr_i[1:0]};

  // Requests are masked by reset so nothing is granted while rst_ni is low.
  assign data_wr = rst_ni & data_req_i & data_we_i;
  assign data_rd = rst_ni & data_req_i & ~data_we_i;
  // An instruction fetch of the word being written this cycle would read
  // stale data from the RAM, so it waits for the write to land.
  assign instr_rd = rst_ni & instr_req_i & ~(data_wr && (instr_word == data_word));

  always_comb begin
    rd_req             = 2'b00;
    rd_req[PORT_INSTR] = instr_rd;
    rd_req[PORT_DATA]  = data_rd;
  end

  ram_rr_arb2 u_rr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .req_i  (rd_req),
    .gnt_o  (rd_gnt)
  );

  assign instr_gnt_o = rd_gnt[PORT_INSTR];
  assign data_gnt_o  = data_wr | rd_gnt[PORT_DATA];

  // Write port: writes never compete, they only block a same-word fetch.
  assign ram_wea_o   = data_wr ? data_be_i : '0;
  assign ram_addra_o = data_word;
  assign ram_dina_o  = data_wdata_i;

  // Read port: at most one of the two read grants is ever set.
  assign ram_enb_o   = rd_gnt[PORT_INSTR] | rd_gnt[PORT_DATA];
  assign ram_addrb_o = rd_gnt[PORT_INSTR] ? instr_word : data_word;

  always_comb begin
    data_resp_d = RESP_NONE;
    if (data_wr) begin
      data_resp_d = RESP_WRITE;
    end else if (rd_gnt[PORT_DATA]) begin
      data_resp_d = RESP_READ;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      instr_pend_q <= 1'b0;
      data_resp_q  <= RESP_NONE;
    end else begin
      instr_pend_q <= rd_gnt[PORT_INSTR];
      data_resp_q  <= data_resp_d;
    end
  end

  assign instr_rvalid_o = instr_pend_q;
  assign instr_rdata_o  = instr_pend_q ? ram_doutb_i : '0;
  assign data_rvalid_o  = (data_resp_q != RESP_NONE);
  assign data_rdata_o   = (data_resp_q == RESP_READ) ? ram_doutb_i : '0;

endmodule
